// File: rtl/cv32e40p_tmr_voter_monitor.sv
// Triple-modular-redundancy voter with persistent-fault tracking: votes three
// replica words, counts error events and degrades to duplex once a replica keeps failing.
module cv32e40p_tmr_voter_monitor #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned PERM_THRESH = 4,
  parameter int unsigned CNT_W       = 16,
  parameter bit          REG_OUT     = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] res1_i,
  input  logic [WIDTH-1:0] res2_i,
  input  logic [WIDTH-1:0] res3_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] result_o,
  output logic             valid_o,
  output logic             faulty_o,
  output logic             uncorrectable_o,
  output logic [2:0]       fault_id_o,
  output logic [2:0]       perm_fault_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam int unsigned     BW     = $clog2(PERM_THRESH + 1);
  localparam logic [BW-1:0]   THRESH = BW'(PERM_THRESH);

  logic [WIDTH-1:0] w_maj;
  logic [WIDTH-1:0] w_result;
  logic             w_tmr;
  logic             w_unc_raw;
  logic             w_faulty_raw;
  logic [2:0]       w_fid_raw;
  logic             w_faulty;
  logic             w_unc;
  logic [2:0]       w_fid;

  logic [2:0]       r_perm;
  logic [BW-1:0]    r_blame [3];
  logic [CNT_W-1:0] r_err_cnt;

  assign w_tmr = (r_perm == 3'b000);

  always_comb begin
    w_maj        = (res1_i & res2_i) | (res1_i & res3_i) | (res2_i & res3_i);
    w_result     = w_maj;
    w_unc_raw    = 1'b0;
    w_fid_raw    = 3'b000;
    w_faulty_raw = 1'b0;
    if (w_tmr) begin
      w_unc_raw = (res1_i != res2_i) && (res1_i != res3_i) && (res2_i != res3_i);
      if (!w_unc_raw) begin
        w_fid_raw = {res3_i != w_maj, res2_i != w_maj, res1_i != w_maj};
      end
      w_faulty_raw = w_unc_raw || (w_fid_raw != 3'b000);
    end else begin
      // Duplex: the lowest-index surviving replica drives the result.
      if (r_perm[0]) begin
        w_result  = res2_i;
        w_unc_raw = (res2_i != res3_i);
      end else if (r_perm[1]) begin
        w_result  = res1_i;
        w_unc_raw = (res1_i != res3_i);
      end else begin
        w_result  = res1_i;
        w_unc_raw = (res1_i != res2_i);
      end
      w_faulty_raw = w_unc_raw;
    end
  end

  assign w_faulty = valid_i & w_faulty_raw;
  assign w_unc    = valid_i & w_unc_raw;
  assign w_fid    = valid_i ? w_fid_raw : 3'b000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perm    <= 3'b000;
      r_err_cnt <= '0;
      for (int k = 0; k < 3; k++) r_blame[k] <= '0;
    end else if (clear_i) begin
      r_perm    <= 3'b000;
      r_err_cnt <= '0;
      for (int k = 0; k < 3; k++) r_blame[k] <= '0;
    end else if (valid_i) begin
      if (w_faulty && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + CNT_W'(1);
      // Only a correctable TMR vote says anything about which replica is at fault.
      if (w_tmr && !w_unc) begin
        for (int k = 0; k < 3; k++) begin
          if (w_fid[k]) begin
            if (r_blame[k] != THRESH) r_blame[k] <= r_blame[k] + BW'(1);
            if ((r_blame[k] + BW'(1)) == THRESH) r_perm[k] <= 1'b1;
          end else begin
            r_blame[k] <= '0;
          end
        end
      end
    end
  end

  assign perm_fault_o = r_perm;
  assign err_cnt_o    = r_err_cnt;

  // Output handshake is valid-only: a sample is accepted every cycle valid_i is
  // high and appears with valid_o high after 0 or 1 cycles; there is no backpressure.
  generate
    if (REG_OUT) begin : g_reg_out
      logic [WIDTH-1:0] r_result;
      logic             r_valid;
      logic             r_faulty;
      logic             r_unc;
      logic [2:0]       r_fid;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_result <= '0;
          r_valid  <= 1'b0;
          r_faulty <= 1'b0;
          r_unc    <= 1'b0;
          r_fid    <= 3'b000;
        end else begin
          r_result <= w_result;
          r_valid  <= valid_i;
          r_faulty <= w_faulty;
          r_unc    <= w_unc;
          r_fid    <= w_fid;
        end
      end

      assign result_o        = r_result;
      assign valid_o         = r_valid;
      assign faulty_o        = r_faulty;
      assign uncorrectable_o = r_unc;
      assign fault_id_o      = r_fid;
    end else begin : g_comb_out
      assign result_o        = w_result;
      assign valid_o         = valid_i;
      assign faulty_o        = w_faulty;
      assign uncorrectable_o = w_unc;
      assign fault_id_o      = w_fid;
    end
  endgenerate

endmodule

// File: tb/tb_cv32e40p_tmr_voter_monitor.sv
// Bench for the TMR voter: one combinational and one registered instance share
// stimulus; a bit-counting reference model feeds an expected queue for both.
module tb_cv32e40p_tmr_voter_monitor;

  localparam int W  = 32;
  localparam int TH = 4;
  localparam int CW = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         valid_i = 1'b0;
  logic         clear_i = 1'b0;
  logic [W-1:0] res1_i = '0;
  logic [W-1:0] res2_i = '0;
  logic [W-1:0] res3_i = '0;

  logic [W-1:0]  c_result, q_result;
  logic          c_valid, q_valid, c_faulty, q_faulty, c_unc, q_unc;
  logic [2:0]    c_fid, q_fid, c_perm, q_perm;
  logic [CW-1:0] c_err, q_err;

  cv32e40p_tmr_voter_monitor #(.WIDTH(W), .PERM_THRESH(TH), .CNT_W(CW), .REG_OUT(1'b0)) u_comb (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .res1_i(res1_i), .res2_i(res2_i),
    .res3_i(res3_i), .clear_i(clear_i), .result_o(c_result), .valid_o(c_valid),
    .faulty_o(c_faulty), .uncorrectable_o(c_unc), .fault_id_o(c_fid),
    .perm_fault_o(c_perm), .err_cnt_o(c_err)
  );

  cv32e40p_tmr_voter_monitor #(.WIDTH(W), .PERM_THRESH(TH), .CNT_W(CW), .REG_OUT(1'b1)) u_reg (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .res1_i(res1_i), .res2_i(res2_i),
    .res3_i(res3_i), .clear_i(clear_i), .result_o(q_result), .valid_o(q_valid),
    .faulty_o(q_faulty), .uncorrectable_o(q_unc), .fault_id_o(q_fid),
    .perm_fault_o(q_perm), .err_cnt_o(q_err)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Packed sample: [37]=valid [36:5]=result [4]=faulty [3]=unc [2:0]=fault_id
  logic [37:0] exp_q[$];
  logic [2:0]  m_perm = 3'b000;
  int          m_blame[3] = '{0, 0, 0};
  int          m_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [37:0] model_out(input logic v, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic [W-1:0] c,
                                            input logic [2:0] perm);
    logic [W-1:0] maj, r, h0, h1;
    logic         f, u;
    logic [2:0]   id;
    for (int i = 0; i < W; i++) maj[i] = ((int'(a[i]) + int'(b[i]) + int'(c[i])) >= 2);
    id = 3'b000;
    if (perm == 3'b000) begin
      r = maj;
      u = (a != b) && (b != c) && (a != c);
      if (!u) id = {c != maj, b != maj, a != maj};
      f = u || (id != 3'b000);
    end else begin
      h0 = perm[0] ? b : a;
      h1 = perm[2] ? b : c;
      r  = h0;
      u  = (h0 != h1);
      f  = u;
    end
    if (!v) begin
      f  = 1'b0;
      u  = 1'b0;
      id = 3'b000;
    end
    return {v, r, f, u, id};
  endfunction

  task automatic compare_out(input string tag, input logic [37:0] act, input logic [37:0] exp);
    check_eq({tag, "_valid"}, 64'(act[37]), 64'(exp[37]));
    if (exp[37]) check_eq({tag, "_result"}, 64'(act[36:5]), 64'(exp[36:5]));
    check_eq({tag, "_faulty"}, 64'(act[4]), 64'(exp[4]));
    check_eq({tag, "_unc"}, 64'(act[3]), 64'(exp[3]));
    check_eq({tag, "_fid"}, 64'(act[2:0]), 64'(exp[2:0]));
  endtask

  // Driver: called at posedge+1; drives one sample, checks both instances.
  task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] c, input logic clr);
    logic [37:0] e;
    valid_i = v; res1_i = a; res2_i = b; res3_i = c; clear_i = clr;
    #2;
    e = model_out(v, a, b, c, m_perm);
    compare_out("comb", {c_valid, c_result, c_faulty, c_unc, c_fid}, e);
    exp_q.push_back(e);
    @(posedge clk);
    if (clr) begin
      m_perm = 3'b000; m_err = 0; m_blame = '{0, 0, 0};
    end else if (v) begin
      if (e[4] && (m_err < (1 << CW) - 1)) m_err++;
      if ((m_perm == 3'b000) && !e[3]) begin
        for (int k = 0; k < 3; k++) begin
          if (e[k]) begin
            if (m_blame[k] < TH) m_blame[k]++;
            if (m_blame[k] == TH) m_perm[k] = 1'b1;
          end else begin
            m_blame[k] = 0;
          end
        end
      end
    end
    #1;
    compare_out("reg", {q_valid, q_result, q_faulty, q_unc, q_fid}, exp_q.pop_front());
    check_eq("comb_perm", 64'(c_perm), 64'(m_perm));
    check_eq("reg_perm", 64'(q_perm), 64'(m_perm));
    check_eq("comb_err", 64'(c_err), 64'(m_err));
    check_eq("reg_err", 64'(q_err), 64'(m_err));
  endtask

  // kind 0: all agree, 1..3: replica kind wrong, 4: all differ
  task automatic rand_step(input int kind, input logic clr);
    logic [W-1:0] base, x, y;
    base = $urandom();
    x = W'(1) << $urandom_range(0, W - 1);
    y = x ^ (W'(1) << $urandom_range(0, W - 1));
    if (y == '0) y = ~x;
    case (kind)
      0:       step(1'b1, base, base, base, clr);
      1:       step(1'b1, base ^ x, base, base, clr);
      2:       step(1'b1, base, base ^ x, base, clr);
      3:       step(1'b1, base, base, base ^ x, clr);
      default: step(1'b1, base, base ^ x, base ^ y, clr);
    endcase
  endtask

  localparam logic [W-1:0] A5 = 32'hA5A5_A5A5;

  initial begin
    #12;
    check_eq("rst_valid", 64'(q_valid), 64'd0);
    check_eq("rst_result", 64'(q_result), 64'd0);
    check_eq("rst_status", 64'({q_faulty, q_unc, q_fid}), 64'd0);
    check_eq("rst_perm", 64'(c_perm), 64'd0);
    check_eq("rst_err", 64'(q_err), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    step(1'b1, A5, A5, A5, 1'b0);
    step(1'b1, A5, 32'hA5A5_A5A4, A5, 1'b0);
    check_eq("err_after_single", 64'(c_err), 64'd1);

    // Three blamed, one clean, three blamed: streak broken, no permanent fault.
    for (int i = 0; i < 3; i++) step(1'b1, A5, A5, A5 ^ 32'h10, 1'b0);
    step(1'b1, A5, A5, A5, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, A5, A5, A5 ^ 32'h10, 1'b0);
    check_eq("perm_streak_broken", 64'(q_perm), 64'd0);

    step(1'b1, 32'd1, 32'd2, 32'd3, 1'b0);
    step(1'b1, 32'd1, 32'd2, 32'd3, 1'b1);
    check_eq("err_after_clear", 64'(c_err), 64'd0);

    for (int i = 0; i < 3; i++) step(1'b0, $urandom(), $urandom(), $urandom(), 1'b0);

    for (int i = 0; i < 4; i++) step(1'b1, 32'h55, 32'h55, 32'h77, 1'b0);
    check_eq("perm_after_4", 64'(q_perm), 64'b100);
    step(1'b1, 32'd1, 32'd2, 32'd9, 1'b0);
    check_eq("dmr_result", 64'(c_result), 64'd1);
    for (int i = 0; i < 6; i++) rand_step($urandom_range(0, 4), 1'b0);

    // Async reset in the middle of a valid stream.
    valid_i = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_valid", 64'(q_valid), 64'd0);
    check_eq("midrst_status", 64'({q_faulty, q_unc, q_fid}), 64'd0);
    check_eq("midrst_perm", 64'(q_perm), 64'd0);
    check_eq("midrst_err", 64'(c_err), 64'd0);
    m_perm = 3'b000; m_err = 0; m_blame = '{0, 0, 0};
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 60; i++) rand_step($urandom_range(0, 4), ($urandom_range(0, 15) == 0));

    step(1'b1, A5, A5, A5, 1'b1);
    for (int i = 0; i < 4; i++) rand_step(1, 1'b0);
    check_eq("perm_res1", 64'(c_perm), 64'b001);
    for (int i = 0; i < 20; i++) rand_step($urandom_range(0, 4), 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 32'd4, 32'd5, 32'd6, 1'b0);
    check_eq("err_saturated", 64'(q_err), 64'((1 << CW) - 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cv32e40p_tmr_voter_monitor.md
CV32E40P_TMR_VOTER_MONITOR -- requirements
Module: cv32e40p_tmr_voter_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 32, width of each replica word.
REQ-002 SHALL have parameter PERM_THRESH, default 4, range 1..255: consecutive blamed samples that declare a replica permanently failed.
REQ-003 SHALL have parameter CNT_W, default 16, width of the error-event counter.
REQ-004 SHALL have parameter REG_OUT, default 0: 0 gives combinational output stage; 1 gives registered output stage.
REQ-005 SHALL have clk  input  1  single clock; all state on rising edge.
REQ-006 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have valid_i  input  1  replica words valid this cycle.
REQ-008 SHALL have res1_i, res2_i, res3_i  input  WIDTH each  replica results.
REQ-009 SHALL have clear_i  input  1  synchronous clear of blame counters, perm_fault_o and err_cnt_o.
REQ-010 SHALL have result_o  output  WIDTH  voted result.
REQ-011 SHALL have valid_o  output  1  result_o and status valid.
REQ-012 SHALL have faulty_o  output  1  at least one healthy replica disagrees with result_o.
REQ-013 SHALL have uncorrectable_o  output  1  no trustworthy majority exists.
REQ-014 SHALL have fault_id_o  output  3  one-hot mismatching replica; bit0 is res1.
REQ-015 SHALL have perm_fault_o  output  3  sticky one-hot permanently failed replica.
REQ-016 SHALL have err_cnt_o  output  CNT_W  saturating count of valid samples with faulty_o=1.

Function
REQ-017 SHALL operate in TMR mode (perm_fault_o==0): result = bitwise majority of res1/2/3.
REQ-018 SHALL in TMR mode set uncorrectable_o=1 iff all three words pairwise differ; fault_id_o=000 in that case.
REQ-019 SHALL otherwise in TMR mode set fault_id_o bit k iff res_k != majority; at most one bit set.
REQ-020 SHALL operate in DMR mode (one perm_fault_o bit set): result = lowest-index healthy replica; failed replica ignored.
REQ-021 SHALL in DMR mode set uncorrectable_o=faulty_o=1 when the two healthy replicas differ; fault_id_o=000.
REQ-022 SHALL keep a per-replica consecutive-blame counter, width clog2(PERM_THRESH+1), saturating at PERM_THRESH.
REQ-023 SHALL, on a valid TMR sample with uncorrectable_o=0, increment the counter of the blamed replica and zero the counters of the other two.
REQ-024 SHALL leave all blame counters unchanged on uncorrectable, DMR or non-valid cycles.
REQ-025 SHALL set perm_fault_o[k] on the edge where counter k reaches PERM_THRESH; the next sample uses DMR mode.
REQ-026 SHALL never set a second perm_fault_o bit; no blame counting in DMR mode.
REQ-027 SHALL increment err_cnt_o on every valid sample with faulty_o=1, saturating at 2^CNT_W-1.
REQ-028 SHALL, when clear_i=1, zero blame counters, perm_fault_o and err_cnt_o on that edge. clear_i wins over a coincident valid_i. The coincident sample is still voted and output, but not counted.
REQ-029 SHALL drive faulty_o, uncorrectable_o and fault_id_o to 0 whenever valid_o=0.
REQ-030 SHALL, with REG_OUT=0, drive valid_o=valid_i and result and status combinationally in the same cycle, with zero latency.
REQ-031 SHALL, with REG_OUT=1, register result_o, valid_o, faulty_o, uncorrectable_o and fault_id_o, for one-cycle latency and one sample per cycle with no stall. Counters and perm_fault_o timing is unchanged.
REQ-032 SHALL drive result_o to the voted value even when valid_i=0 (don't-care for the bench).

Reset
REQ-033 SHALL, while rst_n=0, zero all registers asynchronously: blame counters, perm_fault_o, err_cnt_o, and the registered outputs valid_o, result_o and status.
REQ-034 SHALL, on reset asserted mid-sequence, discard partial blame counts and return to TMR mode.

Verification
REQ-035 SHALL be verified by this scenario: TMR, res=0xA5A5A5A5 x3 -> result 0xA5A5A5A5, faulty_o=0, err_cnt unchanged.
REQ-036 SHALL be verified by this scenario: res2=0xA5A5A5A4, others 0xA5A5A5A5 -> result 0xA5A5A5A5, fault_id_o=010, err_cnt_o+1.
REQ-037 SHALL be verified by this scenario: PERM_THRESH=4, res3 wrong for 4 consecutive valid samples -> perm_fault_o=100 after 4th edge. Then res1=1, res2=2 -> result 1, uncorrectable_o=1.
REQ-038 SHALL be verified by this scenario: res3 wrong 3 samples, one clean sample, then 3 wrong -> perm_fault_o stays 000.
REQ-039 SHALL be verified by this scenario: res=1,2,3 -> uncorrectable_o=1, fault_id_o=000, blame counters unchanged. Then clear_i with valid_i -> err_cnt_o=0.
REQ-040 SHALL be verified by this scenario: REG_OUT=1 with back-to-back valid samples -> each output appears exactly one cycle later. rst_n low mid-stream -> valid_o=0 immediately.
